// File: rtl/complex_sub_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : complex_sub_pipe                                              |
// | Description : Two-stage valid/ready complex subtractor (A - B) with         |
// |               optional saturation and per-component overflow flags.         |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module complex_sub_pipe #(
  parameter int WIDTH    = 8,
  parameter int FRAC     = 2,
  parameter bit SATURATE = 1'b1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [2*WIDTH-1:0]   i_A,
  input  logic [2*WIDTH-1:0]   i_B,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [2*WIDTH-1:0]   o_diff,
  output logic [1:0]           o_ovf
);

  localparam logic [WIDTH-1:0] c_max = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] c_min = {1'b1, {(WIDTH-1){1'b0}}};

  logic                 r_s1_valid;
  logic [2*WIDTH-1:0]   r_s1_a;
  logic [2*WIDTH-1:0]   r_s1_b;
  logic                 r_o_valid;
  logic [2*WIDTH-1:0]   r_diff;
  logic [1:0]           r_ovf;

  logic                 w_s2_en;
  logic                 w_s1_en;
  logic [2*WIDTH-1:0]   w_diff;
  logic [1:0]           w_ovf;

  // The binary point only matters to whoever interprets the samples.
  if (FRAC < 0 || FRAC >= WIDTH) begin : g_frac_check
    $error("complex_sub_pipe: FRAC must lie in [0, WIDTH-1]");
  end

  assign w_s2_en = !r_o_valid || i_ready;
  assign w_s1_en = !r_s1_valid || w_s2_en;
  assign o_ready = w_s1_en;

  // Component 1 is the real part (upper half), component 0 the imaginary part.
  for (genvar c = 0; c < 2; c++) begin : g_comp
    logic [WIDTH:0] w_d;

    assign w_d = {r_s1_a[c*WIDTH+WIDTH-1], r_s1_a[c*WIDTH +: WIDTH]}
               - {r_s1_b[c*WIDTH+WIDTH-1], r_s1_b[c*WIDTH +: WIDTH]};
    // Exact result leaves the WIDTH-bit range exactly when its top two bits differ.
    assign w_ovf[c] = w_d[WIDTH] ^ w_d[WIDTH-1];

    if (SATURATE) begin : g_sat
      assign w_diff[c*WIDTH +: WIDTH] = !w_ovf[c]  ? w_d[WIDTH-1:0] :
                                        w_d[WIDTH] ? c_min : c_max;
    end else begin : g_wrap
      assign w_diff[c*WIDTH +: WIDTH] = w_d[WIDTH-1:0];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
    end else if (w_s1_en) begin
      r_s1_valid <= i_valid;
      if (i_valid) begin
        r_s1_a <= i_A;
        r_s1_b <= i_B;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_o_valid <= 1'b0;
      r_diff    <= '0;
      r_ovf     <= '0;
    end else if (w_s2_en) begin
      r_o_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_diff <= w_diff;
        r_ovf  <= w_ovf;
      end
    end
  end

  assign o_valid = r_o_valid;
  assign o_diff  = r_diff;
  assign o_ovf   = r_ovf;

endmodule
`default_nettype wire
